ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide engine attached to the execute stage; a parametrised successor to the single-cycle EX ALU path.
//  Handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over XLEN bits, BITS_PER_CYCLE bits per iteration.
//  Holds the EX stage via ex_stall until its result is ready, then holds the result until the pipeline advances.
// PARAMETERS
//  XLEN            32  operand/result width; must be even, >= 8
//  BITS_PER_CYCLE  1   bits retired per iteration; must divide XLEN (1, 2, 4)
// PORTS
//  clk        in   1     clock; all state changes on posedge
//  rst        in   1     asynchronous, active-low reset
//  req_valid  in   1     EX holds an M-extension op (opcode op_reg, funct7 = 7'b0000001)
//  funct3     in   3     M op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//  op_a       in   XLEN  rs1 value, already forwarded
//  op_b       in   XLEN  rs2 value, already forwarded
//  advance    in   1     EX->MEM register loads this cycle (no downstream stall)
//  flush      in   1     EX instruction squashed (taken branch or jump)
//  ex_stall   out  1     hold IF/ID/EX: req_valid && state != DONE
//  busy       out  1     state == BUSY
//  done       out  1     state == DONE; result valid
//  result     out  XLEN  selected result; 0 when not done
// BEHAVIOUR
//  Reset (rst low, async): state IDLE, counter 0, all datapath registers 0.
//  - done=0, busy=0, result=0.
//  - ex_stall follows req_valid (combinational from state).
//  States: IDLE, BUSY, DONE. N = XLEN/BITS_PER_CYCLE.
//  IDLE:
//  - If req_valid && !flush, latch funct3 and |op_a|/|op_b| per signedness, record the result sign, load counter = N.
//  - Div-by-zero or signed overflow -> DONE directly; everything else -> BUSY.
//  BUSY:
//  - Each cycle retire BITS_PER_CYCLE bits: shift-add for mul, restoring subtract-shift for div; counter--.
//  - counter hits 0 -> DONE, applying the sign fix (two's-complement negate) on that transition edge.
//  DONE:
//  - result is stable and done=1; ex_stall=0.
//  - advance=1 -> IDLE next cycle (a new request is accepted the cycle after, never in DONE).
//  - advance=0 -> stay in DONE with result held.
//  Latency from accept edge (cycle 0):
//  - normal op: done in cycle N+1, so ex_stall is high for N+1 cycles.
//  - special case: done in cycle 1.
//  Multiply:
//  - 2*XLEN product; MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
//  - MULH: both operands signed. MULHSU: a signed, b unsigned. MULHU: both unsigned.
//  - Sign fix negates the full 2*XLEN product.
//  Divide: quotient truncates toward zero; remainder takes the sign of the dividend.
//  - op_b==0: DIV/DIVU -> all ones; REM/REMU -> op_a.
//  - DIV(MIN_INT, -1) -> MIN_INT; REM(MIN_INT, -1) -> 0.
//  flush (synchronous) wins over every other event:
//  - any state -> IDLE next cycle, done=0, result discarded.
//  - flush with req_valid in IDLE -> nothing accepted.
//  - No partial result is ever exposed.
//  Reset mid-operation: immediate IDLE; the in-flight op is lost and the pipeline re-issues it.
//  Operand changes on op_a/op_b while BUSY/DONE are ignored: operands are latched at accept.
// TESTING
//  1. MUL 7 * 0xFFFFFFFD, BPC=1 -> ex_stall high cycles 0..32; done in cycle 33; result 0xFFFFFFEB.
//  2. MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
//  3. DIV/REM:
//     - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
//     - DIVU 5 / 0 -> 0xFFFFFFFF, done in cycle 1.
//     - REM 0x80000000 % 0xFFFFFFFF -> 0, done in cycle 1.
//  4. DONE with advance=0 for 3 cycles -> result, done held constant and ex_stall=0.
//     - advance=1 -> IDLE; back-to-back second op accepted the following cycle.
//  5. flush asserted in BUSY cycle 10 -> IDLE next cycle, done never asserted.
//     - rst low in BUSY cycle 5 -> immediate IDLE, all outputs 0.
//  6. BPC=2 and BPC=4 builds: repeat 1-3 -> done in cycle 17 and cycle 9 respectively; random ops vs. golden model.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide engine for the EX stage
module ex_muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            advance,
  input  logic            flush,
  output logic            ex_stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(N);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  logic            neg_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] m_q;
  logic [XLEN-1:0] res_q;

  // Accept-time decode: operand signedness, magnitudes and the two short-circuit cases
  logic            a_signed, b_signed, a_neg, b_neg;
  logic            is_div, is_rem, div_zero, div_ovf, special, res_neg;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  assign is_div      = funct3[2];
  assign is_rem      = funct3[1];
  assign a_signed    = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
  assign b_signed    = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
  assign a_neg       = a_signed && op_a[XLEN-1];
  assign b_neg       = b_signed && op_b[XLEN-1];
  assign a_mag       = a_neg ? -op_a : op_a;
  assign b_mag       = b_neg ? -op_b : op_b;
  // Remainder follows the dividend sign; everything else follows the product/quotient sign
  assign res_neg     = (is_div && is_rem) ? a_neg : (a_neg ^ b_neg);
  assign div_zero    = is_div && (op_b == '0);
  assign div_ovf     = is_div && !funct3[0] && (op_a == MIN_INT) && (op_b == '1);
  assign special     = div_zero || div_ovf;
  assign special_res = div_zero ? (is_rem ? op_a : '1) : (is_rem ? '0 : MIN_INT);

  // One iteration step: BITS_PER_CYCLE rounds of shift-add (mul) or restoring subtract-shift (div)
  logic [XLEN-1:0] nhi, nlo;
  logic [XLEN:0]   t;
  always_comb begin
    nhi = hi_q;
    nlo = lo_q;
    t   = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (op_q[2]) begin
        t   = {nhi, nlo[XLEN-1]};
        nlo = {nlo[XLEN-2:0], 1'b0};
        if (t >= {1'b0, m_q}) begin
          t      = t - {1'b0, m_q};
          nlo[0] = 1'b1;
        end
        nhi = t[XLEN-1:0];
      end else begin
        t   = {1'b0, nhi} + (nlo[0] ? {1'b0, m_q} : {(XLEN+1){1'b0}});
        nlo = {t[0], nlo[XLEN-1:1]};
        nhi = t[XLEN:1];
      end
    end
  end

  // Sign fix and result select applied to the final iteration's output
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fin_res;
  always_comb begin
    prod     = {nhi, nlo};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -nlo : nlo;
    rem_fix  = neg_q ? -nhi : nhi;
    case (op_q)
      3'd0:              fin_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:  fin_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:        fin_res = quo_fix;
      default:           fin_res = rem_fix;
    endcase
  end

  // Control FSM and datapath registers; flush overrides every state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
      m_q   <= '0;
      res_q <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q  <= funct3;
            neg_q <= res_neg;
            cnt   <= CNT_LOAD;
            hi_q  <= '0;
            lo_q  <= is_div ? a_mag : b_mag;
            m_q   <= is_div ? b_mag : a_mag;
            if (special) begin
              res_q <= special_res;
              state <= S_DONE;
            end else begin
              state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          hi_q <= nhi;
          lo_q <= nlo;
          cnt  <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            res_q <= fin_res;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (advance) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (state == S_BUSY);
  assign done     = (state == S_DONE);
  assign result   = done ? res_q : '0;
  assign ex_stall = req_valid && (state != S_DONE);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit at BPC 1, 2 and 4
module tb_ex_muldiv_unit;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        advance;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [2:0]  stall_v;
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [31:0] res_v [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      ex_muldiv_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(1 << g)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .advance   (advance),
        .flush     (flush),
        .ex_stall  (stall_v[g]),
        .busy      (busy_v[g]),
        .done      (done_v[g]),
        .result    (res_v[g])
      );
    end
  endgenerate

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Golden model: RV32M semantics straight from wide signed/unsigned arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          ia, ib;
    bit          ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op at posedge+1; waits for all three builds, checks latency/result, holds, then advances
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit special, input int hold, input string tag);
    int          done_cyc [3];
    int          stall_cnt [3];
    logic [31:0] got [3];
    bit          leak [3];
    bit          all_done;
    int          exp_cyc;
    for (int k = 0; k < 3; k++) begin
      done_cyc[k] = -1; stall_cnt[k] = 0; got[k] = '0; leak[k] = 1'b0;
    end
    req_valid = 1'b1; funct3 = f; op_a = a; op_b = b; advance = 1'b0; flush = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom_range(0, 7));
      end
      @(negedge clk);
      all_done = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (stall_v[k]) stall_cnt[k]++;
        if (done_v[k]) begin
          if (done_cyc[k] < 0) begin done_cyc[k] = cyc; got[k] = res_v[k]; end
        end else begin
          all_done = 1'b0;
          if (res_v[k] != 0) leak[k] = 1'b1;
        end
      end
      if (all_done) break;
    end
    for (int k = 0; k < 3; k++) begin
      exp_cyc = special ? 1 : (32 >> k) + 1;
      check($sformatf("%s bpc%0d done_cycle", tag, 1 << k), 64'(done_cyc[k]), 64'(exp_cyc));
      check($sformatf("%s bpc%0d stall_cycles", tag, 1 << k), 64'(stall_cnt[k]), 64'(exp_cyc));
      check($sformatf("%s bpc%0d result", tag, 1 << k), 64'(got[k]), 64'(exp));
      check($sformatf("%s bpc%0d partial_leak", tag, 1 << k), 64'(leak[k]), 64'd0);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        check($sformatf("%s bpc%0d hold%0d {done,stall,result}", tag, 1 << k, h),
              {done_v[k], stall_v[k], res_v[k]}, {1'b1, 1'b0, exp});
    end
    advance = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    advance   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    bit          rs;
    bit          seen_done;
    int          pick;

    rst = 1'b0; req_valid = 1'b1; advance = 1'b0; flush = 1'b0;
    funct3 = '0; op_a = '0; op_b = '0;
    #12;
    check("reset stall_follows_req", 64'(stall_v), 64'h7);
    check("reset busy", 64'(busy_v), 64'h0);
    check("reset done", 64'(done_v), 64'h0);
    for (int k = 0; k < 3; k++) check($sformatf("reset bpc%0d result", 1 << k), 64'(res_v[k]), 64'h0);
    req_valid = 1'b0;
    #1;
    check("reset stall_no_req", 64'(stall_v), 64'h0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    vt.push_back('{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0});
    vt.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0});
    vt.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0});
    vt.push_back('{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0});
    vt.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0});
    vt.push_back('{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0});
    vt.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0});
    vt.push_back('{3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1});
    vt.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
    vt.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
    vt.push_back('{3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b1});
    vt.push_back('{3'd4, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1});
    vt.push_back('{3'd7, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0});
    vt.push_back('{3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0});

    // Table vectors back to back; the first one also sits in DONE for three cycles
    for (int i = 0; i < vt.size(); i++)
      run_op(vt[i].f, vt[i].a, vt[i].b, vt[i].exp, vt[i].special, (i == 0) ? 3 : 0, $sformatf("vec%0d", i));

    // Random ops against the golden model, with the corner operands mixed in
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom; rb = $urandom;
      pick = $urandom_range(0, 9);
      if (pick == 0) rb = 32'd0;
      if (pick == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if (pick == 2) begin ra = 32'($urandom_range(0, 20)); rb = 32'($urandom_range(0, 5)); end
      rs = rf[2] && ((rb == 0) || (!rf[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF));
      run_op(rf, ra, rb, ref_model(rf, ra, rb), rs, 0, $sformatf("rnd%0d f%0d", i, rf));
    end

    // Flush in the middle of BUSY: back to IDLE, nothing ever completes
    req_valid = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5;
    for (int cyc = 1; cyc <= 7; cyc++) begin @(posedge clk); #1; end
    @(negedge clk);
    check("flush busy_before", 64'(busy_v), 64'h7);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("flush busy_after", 64'(busy_v), 64'h0);
    seen_done = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done_v != 0) seen_done = 1'b1;
    end
    check("flush no_done", 64'(seen_done), 64'h0);

    // Flush together with a request in IDLE: nothing accepted
    @(posedge clk); #1;
    req_valid = 1'b1; flush = 1'b1; funct3 = 3'd4; op_a = 32'd9; op_b = 32'd0;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("idle_flush {busy,done}", {busy_v, done_v}, 64'h0);

    // Asynchronous reset mid-operation
    @(posedge clk); #1;
    req_valid = 1'b1; funct3 = 3'd3; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678;
    for (int cyc = 1; cyc <= 5; cyc++) begin @(posedge clk); #1; end
    @(negedge clk);
    check("rst_mid busy_before", 64'(busy_v), 64'h7);
    rst = 1'b0; req_valid = 1'b0;
    #1;
    check("rst_mid {stall,busy,done}", {stall_v, busy_v, done_v}, 64'h0);
    for (int k = 0; k < 3; k++) check($sformatf("rst_mid bpc%0d result", 1 << k), 64'(res_v[k]), 64'h0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    run_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, ref_model(3'd3, 32'hDEAD_BEEF, 32'h1234_5678), 1'b0, 0, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
